// File: rtl/mc_pkg.sv
// Shared definitions for the MOSI frame decoder: beat width, header layout,
// opcode and FSM state encodings.
package mc_pkg;

  localparam int unsigned MOSI_DATA_W = 32;

  // Header beat field positions
  localparam int unsigned HDR_OP_HI   = 31;
  localparam int unsigned HDR_OP_LO   = 30;
  localparam int unsigned HDR_LEN_HI  = 29;
  localparam int unsigned HDR_LEN_LO  = 24;
  localparam int unsigned HDR_ADDR_HI = 23;
  localparam int unsigned HDR_ADDR_LO = 0;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_WACK,
    ST_RHDR,
    ST_RDATA
  } state_e;

endpackage

// File: rtl/frame_beat_cnt.sv
// Per-frame beat counter: counts handshakes and flags the final beat
// (count == len). Self-clears on the last beat so it never wraps in a frame.
module frame_beat_cnt
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == len_i);

  // Next count: clear on request or on the final beat, else step per beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (inc_i && last_o)) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mosi_frame_decoder.sv
// Decodes host MOSI frames (header + optional write beats) into controller
// commands, forwards write data, and returns a response header plus read
// data on MISO.
module mosi_frame_decoder
  import mc_pkg::*;
#(
  parameter int unsigned MOSI_DATA_W = mc_pkg::MOSI_DATA_W,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned LEN_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MOSI_DATA_W-1:0] mosi_data_i,
  input  logic                   mosi_valid_i,
  output logic                   mosi_ready_o,
  output logic [MOSI_DATA_W-1:0] miso_data_o,
  output logic                   miso_valid_o,
  input  logic                   miso_ready_i,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic                   cmd_we_o,
  output logic [ADDR_W-1:0]      cmd_addr_o,
  output logic [LEN_W-1:0]       cmd_len_o,
  output logic                   wdata_valid_o,
  input  logic                   wdata_ready_i,
  output logic [MOSI_DATA_W-1:0] wdata_o,
  input  logic                   rdata_valid_i,
  output logic                   rdata_ready_o,
  input  logic [MOSI_DATA_W-1:0] rdata_i,
  output logic                   err_o
);

  state_e      state_q, state_d;
  logic [31:0] hdr_q, hdr_d;
  logic        err_q, err_d;
  logic        cnt_clr, cnt_inc, cnt_last;
  opcode_e     op_in, op_q;
  logic [LEN_W-1:0] len_q;

  assign op_in      = opcode_e'(mosi_data_i[HDR_OP_HI:HDR_OP_LO]);
  assign op_q       = opcode_e'(hdr_q[HDR_OP_HI:HDR_OP_LO]);
  assign len_q      = hdr_q[HDR_LEN_LO +: LEN_W];
  assign cmd_we_o   = (op_q == OP_WRITE);
  assign cmd_addr_o = hdr_q[HDR_ADDR_LO +: ADDR_W];
  assign cmd_len_o  = len_q;
  assign err_o      = err_q;

  frame_beat_cnt #(
    .CNT_W (LEN_W)
  ) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .len_i  (len_q),
    .last_o (cnt_last)
  );

  // Next-state and output decode; data phases are combinational pass-through.
  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    err_d         = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    mosi_ready_o  = 1'b0;
    miso_valid_o  = 1'b0;
    miso_data_o   = '0;
    cmd_valid_o   = 1'b0;
    wdata_valid_o = 1'b0;
    wdata_o       = '0;
    rdata_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ready is held low while reset is asserted.
        mosi_ready_o = rst;
        cnt_clr      = 1'b1;
        if (mosi_valid_i) begin
          hdr_d = mosi_data_i[31:0];
          case (op_in)
            OP_WRITE, OP_READ: state_d = ST_CMD;
            OP_RSVD:           err_d   = 1'b1;
            default:           ;
          endcase
        end
      end
      ST_CMD: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) begin
          state_d = (op_q == OP_WRITE) ? ST_WDATA : ST_RHDR;
        end
      end
      ST_WDATA: begin
        wdata_valid_o = mosi_valid_i;
        mosi_ready_o  = wdata_ready_i;
        wdata_o       = mosi_data_i;
        cnt_inc       = mosi_valid_i && wdata_ready_i;
        if (cnt_inc && cnt_last) state_d = ST_WACK;
      end
      ST_WACK: begin
        miso_valid_o = 1'b1;
        miso_data_o  = MOSI_DATA_W'({OP_WRITE, hdr_q[HDR_LEN_HI:HDR_ADDR_LO]});
        if (miso_ready_i) state_d = ST_IDLE;
      end
      ST_RHDR: begin
        miso_valid_o = 1'b1;
        miso_data_o  = MOSI_DATA_W'({OP_READ, hdr_q[HDR_LEN_HI:HDR_ADDR_LO]});
        if (miso_ready_i) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        miso_valid_o  = rdata_valid_i;
        rdata_ready_o = miso_ready_i;
        miso_data_o   = rdata_i;
        cnt_inc       = rdata_valid_i && miso_ready_i;
        if (cnt_inc && cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, header and error-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mosi_frame_decoder.sv
// Randomized self-checking bench for mosi_frame_decoder: frames are described
// at transaction level and the captured traffic is compared per frame.
module tb_mosi_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mosi_data_i;
  logic        mosi_valid_i;
  logic        mosi_ready_o;
  logic [31:0] miso_data_o;
  logic        miso_valid_o;
  logic        miso_ready_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic        cmd_we_o;
  logic [23:0] cmd_addr_o;
  logic [5:0]  cmd_len_o;
  logic        wdata_valid_o;
  logic        wdata_ready_i;
  logic [31:0] wdata_o;
  logic        rdata_valid_i;
  logic        rdata_ready_o;
  logic [31:0] rdata_i;
  logic        err_o;

  always #5 clk = ~clk;

  mosi_frame_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .mosi_data_i   (mosi_data_i),
    .mosi_valid_i  (mosi_valid_i),
    .mosi_ready_o  (mosi_ready_o),
    .miso_data_o   (miso_data_o),
    .miso_valid_o  (miso_valid_o),
    .miso_ready_i  (miso_ready_i),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .cmd_we_o      (cmd_we_o),
    .cmd_addr_o    (cmd_addr_o),
    .cmd_len_o     (cmd_len_o),
    .wdata_valid_o (wdata_valid_o),
    .wdata_ready_i (wdata_ready_i),
    .wdata_o       (wdata_o),
    .rdata_valid_i (rdata_valid_i),
    .rdata_ready_o (rdata_ready_o),
    .rdata_i       (rdata_i),
    .err_o         (err_o)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Read data the controller offers for its k-th delivered beat.
  function automatic logic [31:0] rd_val(input int unsigned k);
    return 32'hD000_0000 ^ (k * 32'h0001_9E37);
  endfunction

  function automatic bit rnd(input int unsigned thr);
    return $urandom_range(0, 99) >= thr;
  endfunction

  // Knobs shared by the stimulus processes
  int unsigned thr       = 0;  // percent of cycles a ready/valid is withheld
  int unsigned hthr      = 0;  // max idle cycles before each host beat
  int unsigned cmd_delay = 0;  // cycles cmd_ready stays low once cmd_valid rises
  int unsigned rd_idx    = 0;

  // Captured traffic
  logic [31:0] wq[$];
  logic [31:0] misoq[$];
  logic [30:0] cmdq[$];
  int unsigned hdr_hs_n, err_n, cmd_hi;
  int unsigned hdr_cyc, err_at, cmd_rise;
  int unsigned cyc = 0;

  // Controller and MISO-host side: random throttling, read data held until taken.
  initial begin : responder
    int unsigned cmd_wait;
    bit rd_hs;
    cmd_wait      = 0;
    cmd_ready_i   = 1'b0;
    wdata_ready_i = 1'b0;
    miso_ready_i  = 1'b0;
    rdata_valid_i = 1'b0;
    rdata_i       = rd_val(0);
    forever begin
      @(negedge clk);
      rd_hs = rdata_valid_i && rdata_ready_o;
      if (cmd_valid_o && !cmd_ready_i) cmd_wait++;
      else cmd_wait = 0;
      @(posedge clk);
      #1;
      if (rd_hs) rd_idx++;
      cmd_ready_i   = (cmd_wait >= cmd_delay) && rnd(thr);
      wdata_ready_i = rnd(thr);
      miso_ready_i  = rnd(thr);
      if (!rdata_valid_i || rd_hs) rdata_valid_i = rnd(thr);
      rdata_i = rd_val(rd_idx);
    end
  end

  // Monitor: capture handshakes and check pass-through / hold rules every cycle.
  logic        pv_cmd = 1'b0, pv_miso = 1'b0, pcv = 1'b0;
  logic [31:0] pcmd, pmiso;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pv_cmd  = 1'b0;
      pv_miso = 1'b0;
      pcv     = 1'b0;
    end else begin
      if (pv_cmd)  chk("cmd_hold", {cmd_valid_o, cmd_we_o, cmd_addr_o, cmd_len_o}, pcmd);
      if (pv_miso) chk("miso_hold", {miso_valid_o, miso_data_o}, {1'b1, pmiso});
      pcmd    = {1'b1, cmd_we_o, cmd_addr_o, cmd_len_o};
      pv_cmd  = cmd_valid_o && !cmd_ready_i;
      pmiso   = miso_data_o;
      pv_miso = miso_valid_o && !miso_ready_i;
      if (wdata_valid_o)
        chk("wd_pass", {wdata_o, mosi_ready_o}, {mosi_data_i, wdata_ready_i});
      if (rdata_ready_o)
        chk("rd_pass", {miso_valid_o, miso_data_o}, {rdata_valid_i, rdata_i});
      if (mosi_valid_i && mosi_ready_o && !wdata_valid_o) begin
        hdr_hs_n++;
        hdr_cyc = cyc;
      end
      if (mosi_valid_i && mosi_ready_o && wdata_valid_o) wq.push_back(wdata_o);
      if (cmd_valid_o && cmd_ready_i) cmdq.push_back({cmd_we_o, cmd_addr_o, cmd_len_o});
      if (cmd_valid_o) begin
        cmd_hi++;
        if (!pcv) cmd_rise = cyc;
      end
      pcv = cmd_valid_o;
      if (miso_valid_o && miso_ready_i) misoq.push_back(miso_data_o);
      if (err_o) begin
        err_n++;
        err_at = cyc;
      end
    end
  end

  // Host MOSI beat with optional idle gap; bounded wait for acceptance.
  task automatic send_beat(input logic [31:0] d);
    int unsigned t;
    repeat ($urandom_range(0, hthr)) begin
      @(posedge clk);
      #1;
    end
    mosi_valid_i = 1'b1;
    mosi_data_i  = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (mosi_ready_o) break;
      t++;
      if (t > 2000) begin
        chk("beat_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    mosi_valid_i = 1'b0;
    mosi_data_i  = $urandom;
  endtask

  task automatic clear_capture();
    wq.delete();
    misoq.delete();
    cmdq.delete();
    hdr_hs_n = 0;
    err_n    = 0;
    cmd_hi   = 0;
    hdr_cyc  = 0;
    err_at   = 0;
    cmd_rise = 0;
  endtask

  // Drive one frame and compare all captured traffic against the frame rules.
  task automatic run_frame(input logic [31:0] h);
    logic [1:0]  op;
    logic [5:0]  len;
    logic [23:0] addr;
    logic [31:0] d[64];
    logic [31:0] exp_w;
    int unsigned n, expn, k0, t;
    bit is_wr, is_rd;
    op    = h[31:30];
    len   = h[29:24];
    addr  = h[23:0];
    n     = int'(len) + 1;
    is_wr = (op == 2'b01);
    is_rd = (op == 2'b10);
    expn  = is_wr ? 1 : (is_rd ? n + 1 : 0);
    clear_capture();
    k0 = rd_idx;
    send_beat(h);
    if (is_wr) begin
      for (int i = 0; i < int'(n); i++) begin
        d[i] = $urandom;
        send_beat(d[i]);
      end
    end
    t = 0;
    while (misoq.size() < expn && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) chk("frame_timeout", misoq.size(), expn);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("hdr_acc", hdr_hs_n, 1);
    chk("err_cnt", err_n, (op == 2'b11) ? 1 : 0);
    if (op == 2'b11) chk("err_at", err_at, hdr_cyc + 1);
    chk("cmd_cnt", cmdq.size(), (is_wr || is_rd) ? 1 : 0);
    if ((is_wr || is_rd) && cmdq.size() > 0) begin
      chk("cmd", cmdq[0], {is_wr, addr, len});
      chk("cmd_rise", cmd_rise, hdr_cyc + 1);
    end
    chk("wd_cnt", wq.size(), is_wr ? n : 0);
    for (int i = 0; i < int'(wq.size()) && i < 64 && is_wr; i++) chk("wdata", wq[i], d[i]);
    chk("miso_cnt", misoq.size(), expn);
    for (int i = 0; i < int'(misoq.size()) && i < int'(expn); i++) begin
      exp_w = (i == 0) ? {op, len, addr} : rd_val(k0 + i - 1);
      chk("miso", misoq[i], exp_w);
    end
    chk("back_idle", {mosi_ready_o, cmd_valid_o, miso_valid_o}, 3'b100);
  endtask

  initial begin : main
    int unsigned t;
    rst          = 1'b0;
    mosi_valid_i = 1'b0;
    mosi_data_i  = '0;
    #1;
    chk("rst_valids", {miso_valid_o, cmd_valid_o, wdata_valid_o, err_o, rdata_ready_o}, 0);
    chk("rst_data", {miso_data_o, wdata_o}, 0);
    chk("rst_cmd", {cmd_we_o, cmd_addr_o, cmd_len_o}, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", mosi_ready_o, 1);

    // Write, 2 beats, everything ready
    run_frame(32'h4100_0010);

    // Read, 4 beats, command accepted only after 5 cycles of waiting
    cmd_delay = 5;
    run_frame(32'h8300_0200);
    chk("cmd_hold_cycles", cmd_hi, 6);
    cmd_delay = 0;

    // Reserved opcode then a normal header
    run_frame(32'hC000_0000);
    run_frame(32'h4000_00AB);

    // 64-beat write under random throttling on both sides
    thr  = 40;
    hthr = 2;
    run_frame(32'h7FAB_CDEF);
    thr  = 0;
    hthr = 0;

    // Reset during the read data phase
    clear_capture();
    send_beat(32'h8700_0040);
    t = 0;
    while (misoq.size() < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_wait", misoq.size() >= 3, 1);
    @(posedge clk);
    #2;
    chk("pre_rst_rdata", {miso_valid_o, rdata_ready_o}, 2'b11);
    rst = 1'b0;
    #1;
    chk("mid_rst_valids", {miso_valid_o, cmd_valid_o, wdata_valid_o, err_o, rdata_ready_o}, 0);
    chk("mid_rst_data", {miso_data_o, wdata_o}, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame(32'h0000_0000);
    chk("nop_no_cmd_cycles", cmd_hi, 0);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      logic [31:0] h;
      h = $urandom;
      if (f % 3 == 0) h[29:26] = 4'b0000;
      thr  = $urandom_range(0, 50);
      hthr = $urandom_range(0, 2);
      run_frame(h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
